// File: rtl/ram_burst_reader.sv
// Read sequencer for a single-port RAM: turns (addr, len) commands into a
// ready/valid word stream, absorbing the RAM read latency in a small credit-managed FIFO.
module ram_burst_reader #(
  parameter int unsigned RAM_WIDTH    = 18,
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [ADDR_W:0]      cmd_len,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic                 ram_regcea,
  input  logic [RAM_WIDTH-1:0] ram_douta,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned RemW = ADDR_W + 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FcW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CrW  = FcW + 1;
  localparam int unsigned LatW = $clog2(READ_LATENCY + 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_fifo
    $error("FIFO_DEPTH must be at least READ_LATENCY+1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic                  zdone_q, zdone_d;
  logic                  live_q;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;
  logic [RAM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FcW-1:0]        count_q, count_d;

  logic            accept, issue, push, pop, credit_ok, drain_ok;
  logic [LatW-1:0] inflight;
  logic [ADDR_W-1:0] addr_inc;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + LatW'(tag_vld_q[i]);
    end
  end

  // Credits use registered counts only; a pop this cycle frees its slot next cycle.
  assign credit_ok = (CrW'(count_q) + CrW'(inflight)) < CrW'(FIFO_DEPTH);
  assign issue     = (state_q == StIssue) && (rem_q != '0) && credit_ok;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = tag_vld_q[READ_LATENCY-1];
  assign pop       = m_valid && m_ready;
  assign drain_ok  = (inflight == '0) && (count_q == '0);
  assign addr_inc  = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      zdone_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      zdone_q <= zdone_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    zdone_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_len == '0) begin
            zdone_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d = addr_inc;
          rem_d  = rem_q - RemW'(1);
          if (rem_q == RemW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = live_q && (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = zdone_q || ((state_q == StDrain) && drain_ok);
    ram_ena   = issue;
    ram_wea   = 1'b0;
    ram_addra = addr_q;
    m_valid   = (count_q != '0);
    m_data    = fifo_data_q[rd_ptr_q];
    m_last    = m_valid && fifo_last_q[rd_ptr_q];
  end

  // In-flight tags mirror the RAM pipeline; clearing them on reset discards stale reads.
  always_comb begin
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = issue;
    tag_last_d[0] = issue && (rem_q == RemW'(1));
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
    end
  end

  if (READ_LATENCY > 1) begin : g_regce
    assign ram_regcea = |tag_vld_q[READ_LATENCY-2:0];
  end else begin : g_regce_tied
    assign ram_regcea = live_q;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + FcW'(1);
    if (!push && pop) count_d = count_q - FcW'(1);
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_douta;
        fifo_last_q[wr_ptr_q] <= tag_last_q[READ_LATENCY-1];
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: directed RL=2 scenarios plus a randomised RL=1 run,
// each instance fed by a behavioural RAM model and checked against a word scoreboard.
module tb_ram_burst_reader;

  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ram1_word(input logic [9:0] a);
    return {a, a[7:0]} ^ 18'h2B3C5;
  endfunction

  // ---------------- DUT with READ_LATENCY=2 ----------------
  logic        cmd_valid2, cmd_ready2, ram_ena2, ram_wea2, ram_regcea2;
  logic [9:0]  cmd_addr2, ram_addra2;
  logic [10:0] cmd_len2;
  logic [17:0] ram_douta2, ram2_lat, m_data2;
  logic        m_valid2, m_ready2, m_last2, busy2, done2;

  ram_burst_reader #(.RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(2), .FIFO_DEPTH(FD)) u_dut2 (
    .clka(clk), .rsta_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_addr(cmd_addr2), .cmd_len(cmd_len2), .ram_addra(ram_addra2), .ram_ena(ram_ena2),
    .ram_wea(ram_wea2), .ram_regcea(ram_regcea2), .ram_douta(ram_douta2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .busy(busy2), .done(done2)
  );

  // RAM[k] = k, two-stage read pipeline
  always @(posedge clk) begin
    if (ram_ena2) ram2_lat <= 18'(ram_addra2);
    if (ram_regcea2) ram_douta2 <= ram2_lat;
  end

  // ---------------- DUT with READ_LATENCY=1 ----------------
  logic        cmd_valid1, cmd_ready1, ram_ena1, ram_wea1, ram_regcea1;
  logic [9:0]  cmd_addr1, ram_addra1;
  logic [10:0] cmd_len1;
  logic [17:0] ram_douta1, m_data1;
  logic        m_valid1, m_ready1, m_last1, busy1, done1;

  ram_burst_reader #(.RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(1), .FIFO_DEPTH(FD)) u_dut1 (
    .clka(clk), .rsta_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_addr(cmd_addr1), .cmd_len(cmd_len1), .ram_addra(ram_addra1), .ram_ena(ram_ena1),
    .ram_wea(ram_wea1), .ram_regcea(ram_regcea1), .ram_douta(ram_douta1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1),
    .busy(busy1), .done(done1)
  );

  always @(posedge clk) if (ram_ena1) ram_douta1 <= ram1_word(ram_addra1);

  // ---------------- scoreboards and monitors ----------------
  logic [18:0] sb2[$];
  logic [18:0] sb1[$];
  int iss2, pop2, cmd_iss2, cmd_pop2;
  int iss1, pop1, last1_cnt;
  bit rand_rdy1 = 1'b0;

  task automatic push_exp(input int which, input int a, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 2) sb2.push_back({i == n - 1, 18'((a + i) % 1024)});
      else            sb1.push_back({i == n - 1, ram1_word(10'((a + i) % 1024))});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      iss2 = 0; pop2 = 0;
    end else begin
      if (ram_ena2) begin
        check("credit2", 32'((iss2 - pop2) < FD), 1);
        iss2++; cmd_iss2++;
      end
      if (m_valid2) begin
        if (sb2.size() == 0) check("sb2_unexpected_valid", m_valid2, 0);
        else begin
          check("sb2_word", {m_last2, m_data2}, sb2[0]);
          if (m_ready2) begin
            void'(sb2.pop_front());
            pop2++; cmd_pop2++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      iss1 = 0; pop1 = 0;
    end else begin
      if (ram_ena1) begin
        check("credit1", 32'((iss1 - pop1) < FD), 1);
        iss1++;
      end
      if (m_valid1) begin
        if (sb1.size() == 0) check("sb1_unexpected_valid", m_valid1, 0);
        else begin
          check("sb1_word", {m_last1, m_data1}, sb1[0]);
          if (m_ready1) begin
            void'(sb1.pop_front());
            pop1++;
            if (m_last1) last1_cnt++;
          end
        end
      end
    end
  end

  initial begin
    m_ready1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready1 = rand_rdy1 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive2(input int a, input int n);
    cmd_valid2 = 1'b1;
    cmd_addr2  = 10'(a);
    cmd_len2   = 11'(n);
    cmd_iss2   = 0;
    cmd_pop2   = 0;
    push_exp(2, a, n);
  endtask

  task automatic wait_done2(input string tag, input int limit);
    bit seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    check(tag, seen, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int wa[4];
    int nz, a, n, hits;
    bit got;
    wa = '{1022, 1023, 0, 1};
    rst_n = 1'b0;
    cmd_valid2 = 1'b0; cmd_addr2 = '0; cmd_len2 = '0; m_ready2 = 1'b1;
    cmd_valid1 = 1'b0; cmd_addr1 = '0; cmd_len1 = '0;
    cmd_iss2 = 0; cmd_pop2 = 0; last1_cnt = 0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_ctl2", {cmd_ready2, m_valid2, m_last2, busy2, done2, ram_ena2, ram_regcea2, ram_wea2}, 0);
    check("rst_data2", m_data2, 0);
    check("rst_addr2", ram_addra2, 0);
    check("rst_ctl1", {cmd_ready1, m_valid1, m_last1, busy1, done1, ram_ena1, ram_regcea1, ram_wea1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready2", cmd_ready2, 1);
    check("idle_busy2", busy2, 0);
    check("regce_tied1", ram_regcea1, 1);

    // Basic burst: addr 5, len 4
    drive2(5, 4);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t1_valid", m_valid2, 32'(k >= 4 && k <= 7));
      check("t1_ena", ram_ena2, 32'(k >= 1 && k <= 4));
      check("t1_regce", ram_regcea2, 32'(k >= 2 && k <= 5));
      check("t1_busy", busy2, 32'(k >= 1 && k <= 8));
      check("t1_done", done2, 32'(k == 8));
      check("t1_ready", cmd_ready2, 32'(k == 0 || k >= 9));
      if (k >= 1 && k <= 4) check("t1_addr", ram_addra2, 32'(5 + k - 1));
      @(posedge clk); #1;
      if (k == 0) cmd_valid2 = 1'b0;
    end
    check("t1_sb_empty", sb2.size(), 0);

    // Address wrap: 1022, len 4
    drive2(1022, 4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_ena", ram_ena2, 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) check("t2_addr", ram_addra2, 32'(wa[k-1]));
      @(posedge clk); #1;
      if (k == 0) cmd_valid2 = 1'b0;
    end
    wait_done2("t2_done", 20);
    check("t2_sb_empty", sb2.size(), 0);

    // Backpressure: consumer stalls 10 cycles from the first valid
    m_ready2 = 1'b0;
    drive2(200, 8);
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (m_valid2) got = 1'b1;
    end
    check("t3_first_valid", got, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t3_stall_issues", cmd_iss2, FD);
    check("t3_stall_valid", m_valid2, 1);
    m_ready2 = 1'b1;
    wait_done2("t3_done", 40);
    check("t3_issues", cmd_iss2, 8);
    check("t3_pops", cmd_pop2, 8);
    check("t3_sb_empty", sb2.size(), 0);

    // Zero length
    drive2(7, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_ena", ram_ena2, 0);
      check("t4_valid", m_valid2, 0);
      check("t4_ready", cmd_ready2, 1);
      check("t4_busy", busy2, 0);
      check("t4_done", done2, 32'(k == 1));
      @(posedge clk); #1;
      if (k == 0) cmd_valid2 = 1'b0;
    end

    // Reset mid-burst after 3 words
    drive2(300, 16);
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cmd_pop2 >= 3) break;
      @(posedge clk); #1;
    end
    check("t5_pop3", cmd_pop2, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl2", {cmd_ready2, m_valid2, m_last2, busy2, done2, ram_ena2, ram_regcea2}, 0);
    check("t5_rst_data2", m_data2, 0);
    check("t5_rst_addr2", ram_addra2, 0);
    sb2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_ready", cmd_ready2, 1);
    drive2(100, 2);
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    wait_done2("t5_done", 20);
    check("t5_pops", cmd_pop2, 2);
    check("t5_sb_empty", sb2.size(), 0);

    // READ_LATENCY=1: 64 random commands under random backpressure
    rand_rdy1 = 1'b1;
    nz = 0;
    for (int c = 0; c < 64; c++) begin
      a = int'($urandom_range(0, 1023));
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      if (n != 0) nz++;
      cmd_valid1 = 1'b1;
      cmd_addr1  = 10'(a);
      cmd_len1   = 11'(n);
      push_exp(1, a, n);
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        @(negedge clk);
        if (cmd_ready1) got = 1'b1;
      end
      check("t6_accept", got, 1);
      @(posedge clk); #1;
      cmd_valid1 = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    hits = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (sb1.size() == 0 && !busy1) begin
        hits = 1;
        break;
      end
    end
    check("t6_drained", hits, 1);
    check("t6_last_count", last1_cnt, nz);

    // READ_LATENCY=1 throughput with m_ready held high
    rand_rdy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid1 = 1'b1;
    cmd_addr1  = 10'd1019;
    cmd_len1   = 11'd10;
    push_exp(1, 1019, 10);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("t6_tput_valid", m_valid1, 32'(k >= 3 && k <= 12));
      check("t6_tput_done", done1, 32'(k == 13));
      @(posedge clk); #1;
      if (k == 0) cmd_valid1 = 1'b0;
    end
    check("t6_sb_empty", sb1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Command-driven read sequencer that sits directly upstream of the single-port write-first RAM. It drives the RAM port (address, enable, output-register enable) and converts the RAM's fixed read latency into a ready/valid output stream with backpressure.
- It accepts a (start address, length) command, issues sequential reads, tags the last word, and absorbs in-flight data in a small local FIFO so no read is lost when the consumer stalls.

Parameters:
- RAM_WIDTH, 18, data width; must match the RAM.
- RAM_DEPTH, 1024, RAM entries. ADDR_W = clogb2(RAM_DEPTH-1) is derived, not overridable.
- READ_LATENCY, 2, RAM read latency in clocks. Use 1 for LOW_LATENCY and 2 for HIGH_PERFORMANCE. Only 1 and 2 are legal.
- FIFO_DEPTH, 4, local output FIFO entries. Must be at least READ_LATENCY+2 for full throughput; elaboration error if below READ_LATENCY+1.

Ports:
- clka, input, 1, clock. The block and the RAM both run on this single clock.
- rsta_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, command accepted when cmd_valid&&cmd_ready.
- cmd_addr, input, ADDR_W, start address.
- cmd_len, input, ADDR_W+1, number of words to read. 0 is legal.
- ram_addra, output, ADDR_W, RAM address.
- ram_ena, output, 1, RAM enable; high only on issue cycles.
- ram_wea, output, 1, constant 0.
- ram_regcea, output, 1, RAM output-register enable.
- ram_douta, input, RAM_WIDTH, RAM read data.
- m_valid, output, 1, stream data valid.
- m_ready, input, 1, consumer ready.
- m_data, output, RAM_WIDTH, read word.
- m_last, output, 1, final word of the current command.
- busy, output, 1, command in progress.
- done, output, 1, one-cycle pulse when a command completes.

Behaviour:
- Reset (async assert, sync release) clears all outputs to 0: cmd_ready, m_valid, m_last, m_data, busy, done, ram_ena, ram_regcea, ram_addra. Reset also clears the state, the FIFO, the in-flight tags and all counters.
- Reset mid-burst abandons the command. RAM pipeline contents are ignored after reset because the in-flight tags are cleared.
- State IDLE: cmd_ready=1 and busy=0.
  - On accept with cmd_len=0: done pulses the next cycle and the state stays IDLE.
  - On accept with cmd_len>0: load addr=cmd_addr and remaining=cmd_len, then go to ISSUE. cmd_ready falls on the next cycle.
- State ISSUE: busy=1.
  - Issue condition: remaining>0 && (fifo_count + inflight) < FIFO_DEPTH, using registered counts. A FIFO pop in the same cycle is not credited.
  - On each issue cycle: ram_ena=1 and ram_addra=addr. Then addr advances to addr+1, wrapping from RAM_DEPTH-1 to 0, and remaining decrements.
  - When the issue with remaining==1 occurs, go to DRAIN.
- State DRAIN: wait until inflight==0, the FIFO is empty, and no pop is pending. Then done pulses for 1 cycle and the state returns to IDLE.
- busy is high from the cycle after accept through the done cycle.
- In-flight tracking: a READ_LATENCY-deep shift register of {valid, last}, loaded on each issue cycle. The last bit is set on the issue with remaining==1.
  - ram_regcea=1 whenever any tag in stages 1..READ_LATENCY-1 is valid. For READ_LATENCY=1 it is tied 1.
  - When the final tag stage is valid, ram_douta is written into the FIFO together with its last bit.
- FIFO: registered output. m_valid is high while the FIFO is non-empty, and a pop occurs when m_valid&&m_ready.
  - m_data and m_last hold stable while m_valid&&!m_ready.
  - FIFO overflow cannot occur by construction; the bench asserts this.
- Latency: with the command accepted in cycle 0, the first issue is in cycle 1 and m_valid rises in cycle 2+READ_LATENCY.
- Throughput: 1 word/clock sustained with m_ready=1 and FIFO_DEPTH≥READ_LATENCY+2.
- Consumer stall: issuing stops once fifo_count+inflight reaches FIFO_DEPTH and resumes the cycle after a pop frees a credit.
- A cmd_len above RAM_DEPTH simply wraps the address; words are re-read in order.
- Commands arriving while busy are held off by cmd_ready=0. Commands are never queued.

Test Plan:
- Basic burst, READ_LATENCY=2, RAM[k]=k, cmd_addr=5, cmd_len=4, m_ready=1 -> m_data 5,6,7,8 on 4 consecutive cycles starting in cycle 4; m_last only on 8; done 1 cycle after the last pop.
- Wrap-around, RAM_DEPTH=1024, cmd_addr=1022, cmd_len=4 -> ram_addra sequence 1022,1023,0,1; data 1022,1023,0,1 in order.
- Backpressure: m_ready=0 for 10 cycles after the first m_valid, cmd_len=8 -> exactly FIFO_DEPTH issues happen before the stall, no word is lost or duplicated, m_data is held stable, and the full sequence completes after m_ready=1.
- Zero length, cmd_len=0 -> no ram_ena, no m_valid, done pulses the cycle after accept, cmd_ready stays 1.
- Reset mid-burst: assert rsta_n=0 after 3 words of a 16-word command -> all outputs 0 immediately. A new command cmd_addr=100, cmd_len=2 then returns 100,101 with no stale words.
- READ_LATENCY=1 with random m_ready over 64 random commands -> scoreboard matches RAM contents, m_last count equals the number of nonzero-length commands, throughput is 1/clk when m_ready=1.
